frame_loader: RTL and testbench
===============================

# frame_loader

Write side of the LED matrix frame buffer. Takes a byte stream from the UART receiver, frames it with a sync byte, packs each pixel's R, G and B bytes into one RAM word, and writes the word into the upper-half or lower-half frame RAM. The `matrix` scan driver reads these two RAMs through its `data1`/`data2` ports. The RAM address layout and colour packing are identical to what the scan driver reads.

## Interface
Parameters:
- `length`, 5: shift-register words per row; same value as the scan driver.
- `bitdepth`, 8: bits per colour in RAM; legal range 1..8.
- `scan_bit`, 3: row-select bits; same value as the scan driver.
- `timeout_cycles`, 100000: maximum idle clocks between bytes inside a frame.
- `sync_byte`, 8'hA5: frame start marker.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  byte accepted when `rx_valid && rx_ready`.
- `waddr`  out  `$clog2(addrmax+1)`  RAM word address, where addrmax = length*(1<<scan_bit)-1.
- `wdata`  out  `bitdepth*3`  pixel word.
- `we1`  out  1  write strobe, upper-half RAM.
- `we2`  out  1  write strobe, lower-half RAM.
- `frame_done`  out  1  one-cycle pulse when the last pixel of a frame is written.
- `frame_error`  out  1  one-cycle pulse when a frame is aborted by timeout.

## Operation
- FSM states: IDLE, RED, GREEN, BLUE, WRITE.
- IDLE: accepts and discards bytes. A `sync_byte` clears the pixel index and half flag, then moves to RED. Inside a frame, `sync_byte` is ordinary data.
- RED, GREEN, BLUE: each state accepts one byte and stores `rx_data[bitdepth-1:0]` into colour slot 0, 1 or 2. Slot c occupies `wdata[(c+1)*bitdepth-1 : c*bitdepth]`. After BLUE, the FSM moves to WRITE.
- WRITE: drives `waddr` = pixel index and the strobe for the current half for one cycle.
  - Upper half (half flag = 0) uses `we1`; lower half uses `we2`.
  - The index then increments. When the index passes addrmax in the upper half, it wraps to 0 and the half flag sets.
  - Writing addrmax in the lower half is the last pixel: `frame_done` pulses and the FSM goes to IDLE. Otherwise the FSM goes to RED.
- A frame is exactly 2*(addrmax+1) pixels = 6*(addrmax+1) bytes after the sync byte.
- `rx_ready` = 1 in IDLE, RED, GREEN and BLUE; 0 in WRITE.
- Timeout:
  - The idle counter clears on every accepted byte and counts in RED, GREEN and BLUE.
  - When it reaches `timeout_cycles`, `frame_error` pulses and the FSM enters IDLE.
  - Already-written pixels stay in RAM; index and slots are not preserved.
- Reset, asynchronous at any time including mid-frame: state IDLE; `rx_ready` 1; `waddr` 0; `wdata` 0; `we1`, `we2`, `frame_done`, `frame_error` 0; counters 0.
- Simultaneous events: a byte accepted in the same cycle the timeout would fire takes priority, so no error pulse and the counter clears.

## Timing
- All outputs are registered except `rx_ready`, which decodes from state.
- Blue byte accepted at edge n: `we*`, `waddr` and `wdata` are valid during cycle n+1, exactly one cycle. `frame_done` is coincident with the final write.
- Minimum spacing is 4 cycles per pixel. A back-to-back stream with `rx_valid` held high is stalled one cycle per pixel by `rx_ready`.
- `wdata` holds its value between writes. The RAM samples on `we*` only.
- The scan driver reads asynchronously to writes; no tearing protection is provided.

## Structure
- Shared package `matrix_pkg`:
  - `addrmax` computation function: length, scan_bit → addrmax.
  - Default `sync_byte` constant.
  - FSM state enum.
  - The scan driver and this block both use the package.
- One sub-module, `timeout_counter`: clear / enable / expire, parameterised by `timeout_cycles`. It is reusable for the UART receiver.
- The pixel index, half flag and colour slots stay in `frame_loader`.

## Test plan
- Defaults. Send 0xA5, then 0x12, 0x34, 0x56 → one cycle with `we1`=1, `waddr`=0, `wdata`=24'h563412; `we2`=0.
- Full frame with defaults: 240 bytes, pixel k bytes = k, k, k → 80 writes.
  - Addresses 0..39 on `we1`, then 0..39 on `we2`.
  - `frame_done` pulses once, coincident with `we2` at `waddr`=39.
  - FSM returns to IDLE.
- `bitdepth`=4, byte triple 0xAB, 0xCD, 0xEF → `wdata`=12'hFDB.
- Bytes 0x00, 0xFF, 0x12 in IDLE → no writes. Then 0xA5 and a pixel → write at `waddr`=0. A 0xA5 data byte inside a frame is packed as data.
- `timeout_cycles`=50: after sync and 2 bytes, idle 50 cycles → `frame_error` pulses once. Next 0xA5 plus pixel writes `waddr`=0, `we1`.
- Assert `reset_n`=0 asynchronously mid-GREEN at pixel 17 → outputs take reset values immediately. After release, a new frame starts at `waddr`=0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix frame buffer: the scan driver and the
// frame loader both take the RAM geometry and state encoding from here.
package matrix_pkg;

  // Frame start marker recognised by the loader while idle.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Loader FSM: wait for sync, collect R/G/B, then one write cycle.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RED   = 3'd1,
    GREEN = 3'd2,
    BLUE  = 3'd3,
    WRITE = 3'd4
  } fl_state_e;

  // Highest word address of one half-RAM: length words per row, 2^scan_bit rows.
  function automatic int addrmax_f(input int length, input int scan_bit);
    return length * (1 << scan_bit) - 1;
  endfunction

  // Address width for a RAM whose top address is amax (at least one bit).
  function automatic int addr_w_f(input int amax);
    return (amax > 0) ? $clog2(amax + 1) : 1;
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Idle watchdog: counts enabled cycles since the last clear and flags the cycle
// in which the count would reach timeout_cycles. A clear in that same cycle
// wins, so a late-but-arriving byte never raises an expiry.
module timeout_counter #(
  parameter int timeout_cycles = 100000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (timeout_cycles > 1) ? $clog2(timeout_cycles + 1) : 1;

  logic [CW-1:0] cnt;

  assign expire = en && !clr && (cnt == CW'(timeout_cycles - 1));

  // Idle cycle count; restarts on clear and after it expires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         cnt <= '0;
    else if (clr || expire) cnt <= '0;
    else if (en)          cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/frame_loader.sv
// Write side of the LED matrix frame buffer. Frames the UART byte stream on a
// sync byte, packs R,G,B into one word (R in the low slot) and writes the
// upper-half RAM then the lower-half RAM, each addressed 0..addrmax.
module frame_loader
  import matrix_pkg::*;
#(
  parameter int         length         = 5,
  parameter int         bitdepth       = 8,
  parameter int         scan_bit       = 3,
  parameter int         timeout_cycles = 100000,
  parameter logic [7:0] sync_byte      = SYNC_BYTE,
  localparam int        ADDRMAX        = addrmax_f(length, scan_bit),
  localparam int        AW             = addr_w_f(ADDRMAX)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [AW-1:0]         waddr,
  output logic [bitdepth*3-1:0] wdata,
  output logic                  we1,
  output logic                  we2,
  output logic                  frame_done,
  output logic                  frame_error
);

  localparam logic [AW-1:0] LAST = AW'(ADDRMAX);

  fl_state_e           state;
  logic [AW-1:0]       idx;
  logic                half;
  logic [bitdepth-1:0] slot0, slot1;
  logic                acc, in_pixel, expire;

  // Ready everywhere except the write cycle, which is the per-pixel stall.
  assign rx_ready = (state != WRITE);
  assign acc      = rx_valid && rx_ready;
  assign in_pixel = (state == RED) || (state == GREEN) || (state == BLUE);

  timeout_counter #(.timeout_cycles(timeout_cycles)) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (acc),
    .en     (in_pixel),
    .expire (expire)
  );

  // Frame FSM; write strobes, address and data are issued on the blue byte so
  // they are valid exactly during the WRITE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      half        <= 1'b0;
      slot0       <= '0;
      slot1       <= '0;
      waddr       <= '0;
      wdata       <= '0;
      we1         <= 1'b0;
      we2         <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      we1         <= 1'b0;
      we2         <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (acc && rx_data == sync_byte) begin
            idx   <= '0;
            half  <= 1'b0;
            state <= RED;
          end
        end
        RED: begin
          if (acc) begin
            slot0 <= rx_data[bitdepth-1:0];
            state <= GREEN;
          end else if (expire) begin
            frame_error <= 1'b1;
            state       <= IDLE;
          end
        end
        GREEN: begin
          if (acc) begin
            slot1 <= rx_data[bitdepth-1:0];
            state <= BLUE;
          end else if (expire) begin
            frame_error <= 1'b1;
            state       <= IDLE;
          end
        end
        BLUE: begin
          if (acc) begin
            wdata      <= {rx_data[bitdepth-1:0], slot1, slot0};
            waddr      <= idx;
            we1        <= !half;
            we2        <= half;
            frame_done <= half && (idx == LAST);
            state      <= WRITE;
          end else if (expire) begin
            frame_error <= 1'b1;
            state       <= IDLE;
          end
        end
        WRITE: begin
          if (idx == LAST) begin
            if (half) begin
              state <= IDLE;
            end else begin
              idx   <= '0;
              half  <= 1'b1;
              state <= RED;
            end
          end else begin
            idx   <= idx + AW'(1);
            state <= RED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader: a default instance (a) and a bitdepth=4,
// timeout_cycles=50 instance (b). Writes of instance a are checked against a
// byte-count model of the framing rules.
module tb_frame_loader;

  localparam int N = 40; // words per half with length=5, scan_bit=3

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  a_data = '0, b_data = '0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [5:0]  a_waddr, b_waddr;
  logic [23:0] a_wdata;
  logic [11:0] b_wdata;
  logic        a_we1, a_we2, a_done, a_err;
  logic        b_we1, b_we2, b_done, b_err;

  frame_loader dut_a (
    .clk(clk), .reset_n(reset_n), .rx_data(a_data), .rx_valid(a_valid),
    .rx_ready(a_ready), .waddr(a_waddr), .wdata(a_wdata), .we1(a_we1),
    .we2(a_we2), .frame_done(a_done), .frame_error(a_err)
  );

  frame_loader #(.bitdepth(4), .timeout_cycles(50)) dut_b (
    .clk(clk), .reset_n(reset_n), .rx_data(b_data), .rx_valid(b_valid),
    .rx_ready(b_ready), .waddr(b_waddr), .wdata(b_wdata), .we1(b_we1),
    .we2(b_we2), .frame_done(b_done), .frame_error(b_err)
  );

  typedef struct packed {
    logic        half;
    logic [31:0] addr;
    logic [23:0] data;
    logic        done;
  } wr_t;

  wr_t obs_a[$];
  wr_t exp_a[$];
  int  a_dones = 0, a_errs = 0, a_both = 0, b_writes = 0, b_errs = 0;
  int  cyc = 0;
  int  total = 0, bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe both instances mid-cycle.
  always @(negedge clk) begin
    if (a_we1 || a_we2) obs_a.push_back({a_we2, 32'(a_waddr), a_wdata, a_done});
    if (a_we1 && a_we2) a_both++;
    if (a_done) a_dones++;
    if (a_err) a_errs++;
    if (b_we1 || b_we2) b_writes++;
    if (b_err) b_errs++;
  end

  // Reference: outside a frame only the sync byte matters; inside, byte number
  // k of the frame is colour k%3 of pixel k/3, pixels 0..N-1 go to the upper
  // RAM and N..2N-1 to the lower RAM at address pixel%N.
  bit         m_in = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_pix[3];

  task automatic model_byte(input logic [7:0] b);
    int  p;
    wr_t w;
    if (!m_in) begin
      if (b == 8'hA5) begin
        m_in  = 1'b1;
        m_cnt = 0;
      end
    end else begin
      m_pix[m_cnt % 3] = b;
      if (m_cnt % 3 == 2) begin
        p      = m_cnt / 3;
        w.half = (p >= N);
        w.addr = 32'(p % N);
        w.data = {m_pix[2], m_pix[1], m_pix[0]};
        w.done = (p == 2 * N - 1);
        exp_a.push_back(w);
        if (p == 2 * N - 1) m_in = 1'b0;
      end
      m_cnt++;
    end
  endtask

  task automatic send_a(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    a_data  = b;
    a_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (a_ready) begin @(posedge clk); #1; ok = 1'b1; end
    end
    a_valid = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL send_a byte %h: ready=0 required ready=1 within 20 cycles", b); end
    else model_byte(b);
  endtask

  task automatic send_b(input logic [7:0] b);
    bit ok = 1'b0;
    b_data  = b;
    b_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (b_ready) begin @(posedge clk); #1; ok = 1'b1; end
    end
    b_valid = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL send_b byte %h: ready=0 required ready=1 within 20 cycles", b); end
  endtask

  task automatic clear_obs();
    obs_a.delete(); exp_a.delete();
    m_in = 1'b0; m_cnt = 0;
    a_dones = 0; a_errs = 0; a_both = 0; b_writes = 0; b_errs = 0;
  endtask

  task automatic do_reset();
    a_valid = 1'b0; b_valid = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    clear_obs();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", a_ready); end
    total++; if (a_waddr !== 6'd0) begin bad++; $display("FAIL reset_waddr got %h want 0", a_waddr); end
    total++; if (a_wdata !== 24'd0) begin bad++; $display("FAIL reset_wdata got %h want 0", a_wdata); end
    total++; if ({a_we1, a_we2, a_done, a_err} !== 4'b0) begin bad++; $display("FAIL reset_strobes got %b want 0000", {a_we1, a_we2, a_done, a_err}); end
    do_reset();
  endtask

  task automatic test_single_pixel();
    do_reset();
    send_a(8'hA5, 0); send_a(8'h12, 0); send_a(8'h34, 0); send_a(8'h56, 0);
    total++; if ({a_we1, a_we2} !== 2'b10) begin bad++; $display("FAIL single_we got %b want 10", {a_we1, a_we2}); end
    total++; if (a_waddr !== 6'd0) begin bad++; $display("FAIL single_waddr got %0d want 0", a_waddr); end
    total++; if (a_wdata !== 24'h563412) begin bad++; $display("FAIL single_wdata got %h want 563412", a_wdata); end
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL single_stall_ready got %b want 0", a_ready); end
    @(posedge clk); #1;
    total++; if (a_we1 !== 1'b0) begin bad++; $display("FAIL single_one_cycle we1 got %b want 0", a_we1); end
    total++; if (a_wdata !== 24'h563412) begin bad++; $display("FAIL single_hold wdata got %h want 563412", a_wdata); end
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL single_ready_after got %b want 1", a_ready); end
  endtask

  task automatic test_full_frame();
    do_reset();
    send_a(8'hA5, 0);
    for (int k = 0; k < 2 * N; k++)
      for (int c = 0; c < 3; c++) send_a(8'(k), $urandom_range(0, 2));
    repeat (3) begin @(posedge clk); #1; end
    total++; if (obs_a.size() != 2 * N) begin bad++; $display("FAIL full_count got %0d want %0d", obs_a.size(), 2 * N); end
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      total++;
      if (obs_a[i] !== exp_a[i]) begin bad++; $display("FAIL full_write[%0d] got %h want %h", i, obs_a[i], exp_a[i]); end
    end
    total++; if (a_dones != 1) begin bad++; $display("FAIL full_done_count got %0d want 1", a_dones); end
    total++; if (a_both != 0) begin bad++; $display("FAIL full_both_strobes got %0d want 0", a_both); end
    // Back in IDLE: further non-sync bytes are discarded.
    send_a(8'h07, 0); send_a(8'h07, 0); send_a(8'h07, 0);
    repeat (2) begin @(posedge clk); #1; end
    total++; if (obs_a.size() != 2 * N) begin bad++; $display("FAIL full_idle_after got %0d writes want %0d", obs_a.size(), 2 * N); end
  endtask

  task automatic test_idle_discard();
    do_reset();
    send_a(8'h00, 0); send_a(8'hFF, 1); send_a(8'h12, 0);
    repeat (2) begin @(posedge clk); #1; end
    total++; if (obs_a.size() != 0) begin bad++; $display("FAIL discard_count got %0d want 0", obs_a.size()); end
    send_a(8'hA5, 0); send_a(8'hA5, 0); send_a(8'h01, 0); send_a(8'h7E, 0);
    repeat (2) begin @(posedge clk); #1; end
    total++; if (obs_a.size() != 1) begin bad++; $display("FAIL discard_write_count got %0d want 1", obs_a.size()); end
    else begin
      total++;
      if (obs_a[0] !== {1'b0, 32'd0, 24'h7E01A5, 1'b0}) begin bad++; $display("FAIL sync_as_data got %h want %h", obs_a[0], {1'b0, 32'd0, 24'h7E01A5, 1'b0}); end
    end
  endtask

  task automatic test_random_stream();
    logic [7:0] r;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      r = 8'($urandom_range(0, 255)); if (r == 8'hA5) r = 8'h5A;
      send_a(r, $urandom_range(0, 2));
    end
    send_a(8'hA5, 0);
    for (int i = 0; i < 6 * N; i++) send_a(8'($urandom_range(0, 255)), $urandom_range(0, 2));
    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom_range(0, 255)); if (r == 8'hA5) r = 8'h00;
      send_a(r, $urandom_range(0, 2));
    end
    send_a(8'hA5, 1);
    for (int i = 0; i < 30; i++) send_a(8'($urandom_range(0, 255)), $urandom_range(0, 2));
    repeat (3) begin @(posedge clk); #1; end
    total++; if (obs_a.size() != exp_a.size()) begin bad++; $display("FAIL rand_count got %0d want %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      total++;
      if (obs_a[i] !== exp_a[i]) begin bad++; $display("FAIL rand_write[%0d] got %h want %h", i, obs_a[i], exp_a[i]); end
    end
    total++; if (a_dones != 1) begin bad++; $display("FAIL rand_done_count got %0d want 1", a_dones); end
  endtask

  task automatic test_back_to_back();
    int t0;
    do_reset();
    send_a(8'hA5, 0);
    t0 = cyc;
    for (int i = 0; i < 30; i++) send_a(8'($urandom_range(0, 255)), 0);
    total++; if (cyc - t0 != 39) begin bad++; $display("FAIL b2b_cycles got %0d want 39", cyc - t0); end
    repeat (2) begin @(posedge clk); #1; end
    total++; if (obs_a.size() != 10) begin bad++; $display("FAIL b2b_count got %0d want 10", obs_a.size()); end
    else begin
      total++; if (obs_a[9] !== exp_a[9]) begin bad++; $display("FAIL b2b_last got %h want %h", obs_a[9], exp_a[9]); end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send_a(8'hA5, 0);
    for (int i = 0; i < 17 * 3; i++) send_a(8'($urandom_range(1, 255)), 0);
    send_a(8'h3C, 0); // red of pixel 17, now collecting green
    total++; if (a_waddr !== 6'd16) begin bad++; $display("FAIL mid_pre_waddr got %0d want 16", a_waddr); end
    #3 reset_n = 1'b0;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got %b want 1", a_ready); end
    total++; if (a_waddr !== 6'd0) begin bad++; $display("FAIL mid_waddr got %0d want 0", a_waddr); end
    total++; if (a_wdata !== 24'd0) begin bad++; $display("FAIL mid_wdata got %h want 0", a_wdata); end
    total++; if ({a_we1, a_we2, a_done, a_err} !== 4'b0) begin bad++; $display("FAIL mid_strobes got %b want 0000", {a_we1, a_we2, a_done, a_err}); end
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    clear_obs();
    send_a(8'hA5, 0); send_a(8'h11, 0); send_a(8'h22, 0); send_a(8'h33, 0);
    repeat (2) begin @(posedge clk); #1; end
    total++; if (obs_a.size() != 1) begin bad++; $display("FAIL mid_restart_count got %0d want 1", obs_a.size()); end
    else begin
      total++; if (obs_a[0] !== {1'b0, 32'd0, 24'h332211, 1'b0}) begin bad++; $display("FAIL mid_restart got %h want %h", obs_a[0], {1'b0, 32'd0, 24'h332211, 1'b0}); end
    end
  endtask

  task automatic test_bitdepth4();
    do_reset();
    send_b(8'hA5); send_b(8'hAB); send_b(8'hCD); send_b(8'hEF);
    total++; if ({b_we1, b_we2} !== 2'b10) begin bad++; $display("FAIL bd4_we got %b want 10", {b_we1, b_we2}); end
    total++; if (b_waddr !== 6'd0) begin bad++; $display("FAIL bd4_waddr got %0d want 0", b_waddr); end
    total++; if (b_wdata !== 12'hFDB) begin bad++; $display("FAIL bd4_wdata got %h want FDB", b_wdata); end
  endtask

  task automatic test_timeout();
    do_reset();
    send_b(8'hA5); send_b(8'h11); send_b(8'h22);
    repeat (40) begin @(posedge clk); #1; end
    total++; if (b_errs != 0) begin bad++; $display("FAIL timeout_early got %0d pulses want 0", b_errs); end
    repeat (40) begin @(posedge clk); #1; end
    total++; if (b_errs != 1) begin bad++; $display("FAIL timeout_pulses got %0d want 1", b_errs); end
    total++; if (b_writes != 0) begin bad++; $display("FAIL timeout_writes got %0d want 0", b_writes); end
    send_b(8'hA5); send_b(8'h01); send_b(8'h02); send_b(8'h03);
    total++; if ({b_we1, b_we2, b_waddr} !== {2'b10, 6'd0}) begin bad++; $display("FAIL timeout_restart got we=%b addr=%0d want we=10 addr=0", {b_we1, b_we2}, b_waddr); end
    total++; if (b_wdata !== 12'h321) begin bad++; $display("FAIL timeout_restart_data got %h want 321", b_wdata); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_pixel();
    test_full_frame();
    test_idle_discard();
    test_random_stream();
    test_back_to_back();
    test_reset_midframe();
    test_bitdepth4();
    test_timeout();
    total++; if (a_errs != 0) begin bad++; $display("FAIL a_spurious_error got %0d want 0", a_errs); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
